// File: rtl/lab2_sub_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM state encoding and slice width.
package lab2_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_sub4.sv
// Combinational 4-bit ripple-borrow subtractor slice: d = x - y - bin.
// b3in is the borrow entering bit 3 (used for signed overflow under LAB2_SUB_OVF_EN).
module nibble_sub4
    import lab2_sub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                bin,
    output logic [NIBBLE_W-1:0] d,
    output logic                bout,
    output logic                b3in
);

    logic br;

    always_comb begin
        br   = bin;
        b3in = 1'b0;
        d    = '0;
        for (int i = 0; i < NIBBLE_W; i++) begin
            if (i == NIBBLE_W - 1) begin
                b3in = br;
            end
            d[i] = x[i] ^ y[i] ^ br;
            br   = (~x[i] & y[i]) | (~(x[i] ^ y[i]) & br);
        end
        bout = br;
    end

endmodule

// File: rtl/lab2_nibble_serial_sub.sv
// Nibble-serial W-bit subtractor (diff = a - b - bin), LS nibble first, one nibble per clock.
// Optional macro LAB2_SUB_OVF_EN adds a two's-complement overflow output ovf.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | waiting for start; diff/bout hold the last result
// ST_RUN  | one nibble per edge through the slice, idx selects the nibble
// ST_DONE | one-cycle done pulse; start here is accepted as in IDLE
module lab2_nibble_serial_sub
    import lab2_sub_pkg::*;
#(
    parameter  int NIBBLES = 4,
    localparam int W       = NIBBLE_W * NIBBLES
)(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef LAB2_SUB_OVF_EN
   ,output logic         ovf
`endif
);

    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic [IW-1:0]       idx;
    logic [W-1:0]        a_q;
    logic [W-1:0]        b_q;
    logic                borrow_q;
    logic [W-1:0]        diff_q;
    logic                bout_q;

    logic                accept;
    logic                step;
    logic                last;

    logic [NIBBLE_W-1:0] slice_x;
    logic [NIBBLE_W-1:0] slice_y;
    logic [NIBBLE_W-1:0] slice_d;
    logic                slice_bout;
    logic                slice_b3in;
    logic [W-1:0]        diff_wr;

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                step = 1'b1;
                if (idx == LAST_IDX) begin
                    last      = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

    // Nibble mux into the slice and the matching result-nibble write.
    always_comb begin
        slice_x = '0;
        slice_y = '0;
        diff_wr = diff_q;
        for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
                slice_x = a_q[n*NIBBLE_W +: NIBBLE_W];
                slice_y = b_q[n*NIBBLE_W +: NIBBLE_W];
                diff_wr[n*NIBBLE_W +: NIBBLE_W] = slice_d;
            end
        end
    end

    nibble_sub4 u_slice (
        .x    (slice_x),
        .y    (slice_y),
        .bin  (borrow_q),
        .d    (slice_d),
        .bout (slice_bout),
        .b3in (slice_b3in)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                idx      <= '0;
                diff_q   <= '0;
            end else if (step) begin
                diff_q   <= diff_wr;
                borrow_q <= slice_bout;
                idx      <= idx + IW'(1);
                if (last) begin
                    bout_q <= slice_bout;
                end
            end
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;

`ifdef LAB2_SUB_OVF_EN
    logic ovf_q;

    // Signed overflow: borrow into the top bit differs from borrow out of it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (step && last) begin
            ovf_q <= slice_b3in ^ slice_bout;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_b3in;
    assign unused_b3in = slice_b3in;
`endif

endmodule

// File: doc/lab2_nibble_serial_sub.md
Name: lab2_nibble_serial_sub

Overview:
- Multi-cycle wide subtractor: computes diff = a - b - bin over W = 4*NIBBLES bits, one 4-bit nibble per clock, least-significant nibble first.
- Sits around a 4-bit borrow subtractor slice: feeds it one operand nibble pair plus a registered borrow each cycle, and consumes its difference and borrow-out.
- Lets the lab's 4-bit subtractors build 8/16/32-bit subtraction without widening the combinational datapath.

Parameters:
NIBBLES, 4, number of 4-bit slices; W = 4*NIBBLES; legal range 1..16.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE or DONE
a  in  W  minuend; sampled with start
b  in  W  subtrahend; sampled with start
bin  in  1  borrow-in to nibble 0; sampled with start
busy  out  1  high while in RUN
done  out  1  one-cycle pulse when diff/bout become valid
diff  out  W  result; held until next accepted start
bout  out  1  borrow-out of the top nibble; held with diff

Behaviour:
- Reset, asynchronous, rst_n=0: state=IDLE, idx=0, borrow reg=0, operand regs=0, busy=0, done=0, diff=0, bout=0.
- Reset mid-RUN aborts the operation. No partial result survives.
- FSM states are IDLE, RUN and DONE.
- IDLE: start=1 at an edge latches a, b and bin (bin goes into the borrow reg), sets idx=0, and moves to RUN with busy=1.
- RUN: at each edge, slice input is {a[4idx+3:4idx], b[4idx+3:4idx], borrow}. The edge writes the slice difference into diff[4idx+3:4idx] and the slice borrow-out into the borrow reg, then idx increments.
- RUN exit: on the edge that writes nibble NIBBLES-1, go to DONE, set bout to the final borrow, done=1, busy=0.
- Latency: start sampled at edge k gives done=1 in the cycle after edge k+NIBBLES.
- DONE lasts exactly one cycle, then returns to IDLE. start=1 in DONE is accepted exactly as in IDLE, so back-to-back operations run with zero idle cycles.
- start while busy=1 is ignored. Operands and the in-flight result are unaffected.
- diff is zeroed when a start is accepted. Nibbles fill progressively during RUN. diff and bout are valid only when done=1 or after done until the next accepted start.
- Arithmetic is unsigned modulo 2^W. bout=1 iff a < b + bin as unsigned integers.
- NIBBLES=1: RUN lasts one cycle, and the module is equivalent to one registered slice.

Optional Feature:
- Macro: LAB2_SUB_OVF_EN.
- Defined: adds output port ovf (1 bit), reset value 0, updated with bout. ovf=1 iff the two's-complement value a - b - bin lies outside [-2^(W-1), 2^(W-1)-1]. Computed as the borrow into bit W-1 XOR the borrow out of bit W-1, so the slice must expose its internal borrow into bit 3.
- Undefined: port ovf and its logic are absent. All other behaviour is identical.

Decomposition:
- Shared package lab2_sub_pkg: state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2; NIBBLE_W=4.
- Sub-module nibble_sub4: a combinational 4-bit ripple-borrow slice with inputs x, y, bin and outputs d, bout, plus b3in (borrow into bit 3, used only under LAB2_SUB_OVF_EN).
- Top holds the FSM, idx counter, operand, borrow and result registers.

Test Plan (NIBBLES=4):
- a=16'h1234, b=16'h0111, bin=0, start one cycle -> busy high 4 cycles; done pulse 4 cycles after the start edge; diff=16'h1123; bout=0.
- a=16'h0000, b=16'h0001, bin=0 -> borrow ripples through all nibbles; diff=16'hFFFF; bout=1.
- a=16'h5555, b=16'h5555, bin=1 -> diff=16'hFFFF, bout=1. Then a start in the DONE cycle with a=16'h9999, b=16'h9999, bin=0 -> diff=16'h0000, bout=0, with no idle gap.
- start held high throughout RUN with changing a/b -> only the first operands are used. Result is as in the first scenario, and exactly one done pulse occurs.
- rst_n pulled low during the 2nd RUN cycle -> busy, done, diff and bout go to 0 immediately, without waiting for a clock edge. After release, a fresh start with a=16'h1234, b=16'h0111 gives 16'h1123.
- With LAB2_SUB_OVF_EN: a=16'h8000, b=16'h0001, bin=0 -> diff=16'h7FFF, bout=0, ovf=1. Then a=16'h0003, b=16'h0005 -> diff=16'hFFFE, bout=1, ovf=0.
